vector_writeback_buffer: RTL and testbench

- Sits directly downstream of the vector execution unit and upstream of the vector register file write port.
- Captures each completed execution result and merges it element-wise with the old destination contents under mask (vm/v0) and vl.
- Queues merged results in a small FIFO and drains them to the register file over a valid/ready handshake.
- Decouples execution completion from register-file write availability.

---
 rtl/vector_writeback_buffer.sv | 136 +++++++++++++
 tb/tb_vector_writeback_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback_buffer.sv
// Vector writeback buffer: merges execution results with the old destination
// under mask/vl and queues them for the register-file write port.
module vector_writeback_buffer #(
    parameter int VLEN   = 512,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int VL_W   = $clog2(VLEN/8) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   exe_valid,
    output logic                   exe_ready,
    input  logic [VLEN-1:0]        exe_result,
    input  logic [VLEN-1:0]        exe_old_vd,
    input  logic [VLEN/8-1:0]      exe_mask,
    input  logic                   exe_vm,
    input  logic [VL_W-1:0]        exe_vl,
    input  logic [1:0]             exe_sew,
    input  logic [ADDR_W-1:0]      exe_vd_addr,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [VLEN-1:0]        wb_data,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [VLEN/8-1:0]      wb_be,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_sew
);
    localparam int NB = VLEN / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [VLEN-1:0]   data_q [DEPTH];
    logic [VLEN-1:0]   data_d [DEPTH];
    logic [NB-1:0]     be_q   [DEPTH];
    logic [NB-1:0]     be_d   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    logic [VL_W-1:0]   ne;
    logic [VL_W-1:0]   evl;
    logic [NB-1:0]     byte_act;
    logic [VLEN-1:0]   merged;
    logic              illegal;
    logic              accept;
    logic              push;
    logic              pop;

    always_comb begin
        case (exe_sew)
            2'b01:   ne = VL_W'(NB / 2);
            2'b10:   ne = VL_W'(NB / 4);
            default: ne = VL_W'(NB);
        endcase
        evl = (exe_vl < ne) ? exe_vl : ne;
    end

    // Each byte inherits the active state of the element that owns it.
    always_comb begin
        byte_act = '0;
        merged   = '0;
        for (int b = 0; b < NB; b++) begin
            case (exe_sew)
                2'b01: byte_act[b] = (VL_W'(b / 2) < evl)
                                     && (exe_vm || exe_mask[b / 2]);
                2'b10: byte_act[b] = (VL_W'(b / 4) < evl)
                                     && (exe_vm || exe_mask[b / 4]);
                default: byte_act[b] = (VL_W'(b) < evl)
                                       && (exe_vm || exe_mask[b]);
            endcase
            merged[b*8 +: 8] = byte_act[b] ? exe_result[b*8 +: 8]
                                           : exe_old_vd[b*8 +: 8];
        end
    end

    assign illegal    = (exe_sew == 2'b11);
    assign exe_ready  = reset && (count_q < CW'(DEPTH));
    assign accept     = exe_valid && exe_ready;
    assign push       = accept && !illegal && (|byte_act);
    assign wb_valid   = (count_q != '0);
    assign pop        = wb_valid && wb_ready;
    assign wb_data    = wb_valid ? data_q[rd_ptr_q] : '0;
    assign wb_be      = wb_valid ? be_q[rd_ptr_q] : '0;
    assign wb_addr    = wb_valid ? addr_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign err_sew    = err_q;

    always_comb begin
        data_d   = data_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (accept && illegal);
        if (push) begin
            data_d[wr_ptr_q] = merged;
            be_d[wr_ptr_q]   = byte_act;
            addr_d[wr_ptr_q] = exe_vd_addr;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                be_q[i]   <= '0;
                addr_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_vector_writeback_buffer.sv
// Randomised and directed bench for vector_writeback_buffer against a
// queue-based reference model of merge, drop and FIFO ordering.
module tb_vector_writeback_buffer;
    localparam int VLEN   = 512;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int VL_W   = 7;
    localparam int NB     = VLEN / 8;

    typedef logic [VLEN-1:0] w_t;

    typedef struct {
        logic [VLEN-1:0]   d;
        logic [NB-1:0]     be;
        logic [ADDR_W-1:0] a;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              exe_valid = 1'b0;
    logic              exe_ready;
    logic [VLEN-1:0]   exe_result = '0;
    logic [VLEN-1:0]   exe_old_vd = '0;
    logic [NB-1:0]     exe_mask = '0;
    logic              exe_vm = 1'b0;
    logic [VL_W-1:0]   exe_vl = '0;
    logic [1:0]        exe_sew = '0;
    logic [ADDR_W-1:0] exe_vd_addr = '0;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [VLEN-1:0]   wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic [NB-1:0]     wb_be;
    logic [2:0]        fifo_count;
    logic              err_sew;

    vector_writeback_buffer #(
        .VLEN(VLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .VL_W(VL_W)
    ) dut (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_result(exe_result), .exe_old_vd(exe_old_vd),
        .exe_mask(exe_mask), .exe_vm(exe_vm), .exe_vl(exe_vl),
        .exe_sew(exe_sew), .exe_vd_addr(exe_vd_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_be(wb_be),
        .fifo_count(fifo_count), .err_sew(err_sew)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    logic err_m = 1'b0;
    logic last_acc = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input w_t got, input w_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic ent_t merge();
        ent_t e;
        int esz, ne, evl, i;
        logic act;
        esz = 8 << exe_sew;
        ne  = VLEN / esz;
        evl = (int'(exe_vl) < ne) ? int'(exe_vl) : ne;
        for (int k = 0; k < VLEN; k++) begin
            i = k / esz;
            act = (i < evl) && (exe_vm || exe_mask[i]);
            e.d[k] = act ? exe_result[k] : exe_old_vd[k];
        end
        for (int j = 0; j < NB; j++) begin
            i = (j * 8) / esz;
            e.be[j] = (i < evl) && (exe_vm || exe_mask[i]);
        end
        e.a = exe_vd_addr;
        return e;
    endfunction

    task automatic compare_outputs();
        ent_t h;
        logic ev;
        ev = (q.size() != 0);
        if (ev) h = q[0];
        else begin
            h.d = '0; h.be = '0; h.a = '0;
        end
        check("wb_valid", w_t'(wb_valid), w_t'(ev));
        check("wb_data", wb_data, h.d);
        check("wb_be", w_t'(wb_be), w_t'(h.be));
        check("wb_addr", w_t'(wb_addr), w_t'(h.a));
        check("fifo_count", w_t'(fifo_count), w_t'(q.size()));
        check("exe_ready", w_t'(exe_ready),
              w_t'(reset && (q.size() < DEPTH)));
        check("err_sew", w_t'(err_sew), w_t'(err_m));
    endtask

    task automatic cycle();
        logic acc, pop, psh;
        ent_t e;
        @(negedge clk);
        compare_outputs();
        acc = exe_valid && reset && (q.size() < DEPTH);
        pop = reset && (q.size() != 0) && wb_ready;
        psh = 1'b0;
        if (acc) begin
            if (exe_sew == 2'b11) err_m = 1'b1;
            else begin
                e = merge();
                psh = |e.be;
            end
        end
        if (pop) void'(q.pop_front());
        if (psh) q.push_back(e);
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic push_hold();
        int t = 0;
        exe_valid = 1'b1;
        do begin
            cycle();
            t++;
        end while (!last_acc && t < 20);
        check("accept_bound", w_t'(last_acc), w_t'(1'b1));
    endtask

    function automatic w_t rnd_w();
        w_t r;
        for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_in(input logic vm, input logic [1:0] sew, input int vl,
                          input logic [NB-1:0] m, input w_t res, input w_t old,
                          input logic [ADDR_W-1:0] a);
        exe_vm = vm; exe_sew = sew; exe_vl = VL_W'(vl); exe_mask = m;
        exe_result = res; exe_old_vd = old; exe_vd_addr = a;
    endtask

    task automatic set_rand();
        exe_valid = ($urandom % 4) != 0;
        wb_ready  = ($urandom % 3) != 0;
        set_in($urandom % 2,
               (($urandom % 12) == 0) ? 2'b11 : 2'($urandom % 3),
               $urandom_range(0, 64), {$urandom, $urandom},
               rnd_w(), rnd_w(), ADDR_W'($urandom));
        if (($urandom % 6) == 0) exe_mask = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        repeat (2) cycle();
        check("rst_ready", w_t'(exe_ready), w_t'(1'b0));
        reset = 1'b1;
        cycle();

        set_in(1, 2'b00, 64, '0, {64{8'hAA}}, '0, 5'd3);
        exe_valid = 1'b1;
        cycle();
        exe_valid = 1'b0;
        check("basic_data", wb_data, {64{8'hAA}});
        check("basic_be", w_t'(wb_be), w_t'({NB{1'b1}}));
        check("basic_count", w_t'(fifo_count), w_t'(1));
        wb_ready = 1'b1;
        cycle();
        check("basic_drain", w_t'(fifo_count), w_t'(0));
        check("basic_valid", w_t'(wb_valid), w_t'(0));

        wb_ready = 1'b0;
        set_in(0, 2'b10, 3, 64'h5, {16{32'h11111111}}, {16{32'hFFFFFFFF}}, 5'd4);
        exe_valid = 1'b1;
        cycle();
        exe_valid = 1'b0;
        check("mask_data", wb_data, {{13{32'hFFFFFFFF}}, 32'h11111111,
                                     32'hFFFFFFFF, 32'h11111111});
        check("mask_be", w_t'(wb_be), w_t'(64'h0F0F));
        wb_ready = 1'b1;
        cycle();

        wb_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            v = 32'(n + 1);
            set_in(1, 2'b10, 16, '0, {16{v}}, '0, ADDR_W'(n + 1));
            push_hold();
        end
        check("bp_count", w_t'(fifo_count), w_t'(4));
        check("bp_ready", w_t'(exe_ready), w_t'(0));
        set_in(1, 2'b10, 16, '0, {16{32'd5}}, '0, 5'd5);
        repeat (2) cycle();
        check("bp_hold_addr", w_t'(wb_addr), w_t'(1));
        check("bp_hold_data", wb_data, {16{32'd1}});
        wb_ready = 1'b1;
        push_hold();
        exe_valid = 1'b0;
        repeat (6) cycle();
        check("bp_empty", w_t'(fifo_count), w_t'(0));

        wb_ready = 1'b0;
        set_in(1, 2'b01, 32, '0, rnd_w(), rnd_w(), 5'd7);
        push_hold();
        set_in(1, 2'b01, 32, '0, rnd_w(), rnd_w(), 5'd8);
        push_hold();
        set_in(1, 2'b01, 32, '0, rnd_w(), rnd_w(), 5'd9);
        wb_ready = 1'b1;
        cycle();
        exe_valid = 1'b0;
        check("sim_count", w_t'(fifo_count), w_t'(2));
        check("sim_head", w_t'(wb_addr), w_t'(8));
        repeat (3) cycle();

        set_in(1, 2'b00, 0, '0, rnd_w(), rnd_w(), 5'd10);
        exe_valid = 1'b1;
        cycle();
        check("drop_vl0_count", w_t'(fifo_count), w_t'(0));
        check("drop_vl0_err", w_t'(err_sew), w_t'(0));
        exe_sew = 2'b11;
        exe_vl = 7'd8;
        cycle();
        exe_valid = 1'b0;
        check("drop_sew_count", w_t'(fifo_count), w_t'(0));
        check("drop_sew_err", w_t'(err_sew), w_t'(1));
        repeat (3) cycle();
        check("err_sticky", w_t'(err_sew), w_t'(1));

        for (int c = 0; c < 400; c++) begin
            set_rand();
            cycle();
        end

        exe_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (6) cycle();
        wb_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_in(1, 2'b00, 64, '0, rnd_w(), rnd_w(), ADDR_W'(n + 20));
            push_hold();
        end
        exe_valid = 1'b0;
        check("pre_rst_count", w_t'(fifo_count), w_t'(3));
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", w_t'(wb_valid), w_t'(0));
        check("arst_count", w_t'(fifo_count), w_t'(0));
        check("arst_data", wb_data, '0);
        check("arst_be", w_t'(wb_be), w_t'(0));
        check("arst_addr", w_t'(wb_addr), w_t'(0));
        check("arst_ready", w_t'(exe_ready), w_t'(0));
        check("arst_err", w_t'(err_sew), w_t'(0));
        q.delete();
        err_m = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;

        for (int c = 0; c < 300; c++) begin
            set_rand();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
